// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map for the MMIO UART transmitter
// Optional UART_TX_PARITY_EN adds the PARITY state to the FSM enum.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_e;

  localparam logic [15:0] TXDATA_OFS = 16'd0;
  localparam logic [15:0] STATUS_OFS = 16'd4;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO with show-ahead head output
// A push while full is accepted only when a pop frees a slot in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full_o    = (r_count == (AW+1)'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign dout_o    = r_mem[r_rd_ptr];
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din_i;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with TX FIFO and status register
// Define UART_TX_PARITY_EN for 11-bit frames with an even parity bit.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] BASE_ADDR    = 16'h8000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [15:0] TX_ADDR  = BASE_ADDR + TXDATA_OFS;
  localparam logic [15:0] ST_ADDR  = BASE_ADDR + STATUS_OFS;

  uart_state_e r_state;
  uart_state_e w_next;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_ovf;
  logic [31:0]   r_rdata;
  logic          w_pop;
  logic          w_line;
  logic          w_wrap;
  logic          w_wr_tx;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic [7:0]    w_dout;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_count;
  logic [31:0]   w_status;
  logic          w_unused_data;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  assign w_unused_data = ^data_i[31:8];
  assign w_wrap    = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_wr_tx   = we_i & (addr_i == TX_ADDR);
  assign w_ovf_set = w_wr_tx & w_full & ~w_pop;
  assign w_ovf_clr = we_i & (addr_i == ST_ADDR) & data_i[STAT_OVF];
  assign busy_o    = (r_state != ST_IDLE) | ~w_empty;
  assign tx_o      = r_tx;
  assign rdata_o   = r_rdata;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_wr_tx),
    .pop_i   (w_pop),
    .din_i   (data_i[7:0]),
    .dout_o  (w_dout),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  always_comb begin
    w_status                          = '0;
    w_status[STAT_FULL]               = w_full;
    w_status[STAT_EMPTY]              = w_empty;
    w_status[STAT_BUSY]               = busy_o;
    w_status[STAT_OVF]                = r_ovf;
    w_status[STAT_CNT_LSB +: AW+1]    = w_count;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_line = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = ST_START;
        end
      end
      ST_START: begin
        w_line = 1'b0;
        if (w_wrap) w_next = ST_DATA;
      end
      ST_DATA: begin
        w_line = r_shift[0];
        if (w_wrap && r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          w_next = ST_PARITY;
`else
          w_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        w_line = r_par;
        if (w_wrap) w_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_wrap) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The line register follows the state one cycle later, so every bit keeps its full width.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_tx    <= w_line;
      if (r_state == ST_IDLE || w_next != r_state || w_wrap) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + BW'(1);
      end
      if (w_pop) begin
        r_shift <= w_dout;
        r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
        r_par   <= ^w_dout;
`endif
      end else if (r_state == ST_DATA && w_wrap) begin
        r_shift <= {1'b0, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
    end
  end

  // An overflow in the same cycle as a clear wins, so no dropped byte goes unreported.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ovf   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
      if (re_i) begin
        r_rdata <= (addr_i == ST_ADDR) ? w_status : 32'd0;
      end
    end
  end

endmodule
